// File: rtl/scan_cfg_ctrl.sv
// Loads a CLB scan chain LSB-first from a valid/ready word stream, holding scan_en while shifting.
// Define SCAN_CFG_READBACK_EN to add a recirculating readback pass with a CRC-8 compare.
module scan_cfg_ctrl #(
  parameter int CHAIN_LEN = 29,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_en,
  output logic              scan_data,
  input  logic              scan_ret,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int                WCNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  TOT_LAST  = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
`ifdef SCAN_CFG_READBACK_EN
    S_VERIFY,
`endif
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  tot_q, tot_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              error_q, error_d;
  logic              scan_en_d, scan_data_d;
  logic              cfg_ready_q, scan_en_q, scan_data_q, busy_q, done_q;

`ifdef SCAN_CFG_READBACK_EN
  logic [7:0] crc_tx_q, crc_tx_d, crc_rb_q, crc_rb_d;
  logic       verify_q;

  // Serial CRC-8, polynomial x^8+x^2+x+1, MSB-first feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    tot_d   = tot_q;
    wcnt_d  = wcnt_q;
    error_d = error_q;
`ifdef SCAN_CFG_READBACK_EN
    crc_tx_d = crc_tx_q;
    crc_rb_d = crc_rb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          error_d = 1'b0;
          tot_d   = '0;
          wcnt_d  = '0;
`ifdef SCAN_CFG_READBACK_EN
          crc_tx_d = '0;
          crc_rb_d = '0;
`endif
        end
      end
      S_LOAD: begin
        if (cfg_valid) begin
          sreg_d  = cfg_data;
          wcnt_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = sreg_q >> 1;
        wcnt_d = wcnt_q + WCNT_W'(1);
        tot_d  = tot_q + CNT_W'(1);
`ifdef SCAN_CFG_READBACK_EN
        crc_tx_d = crc8_step(crc_tx_q, sreg_q[0]);
`endif
        // The chain length wins over a word boundary, so spare high bits of the last word are dropped.
        if (tot_d == TOT_LAST) begin
`ifdef SCAN_CFG_READBACK_EN
          state_d = S_VERIFY;
          tot_d   = '0;
`else
          state_d = S_FINISH;
`endif
        end else if (wcnt_d == WORD_LAST) begin
          state_d = S_LOAD;
        end
      end
`ifdef SCAN_CFG_READBACK_EN
      S_VERIFY: begin
        tot_d    = tot_q + CNT_W'(1);
        crc_rb_d = crc8_step(crc_rb_q, scan_ret);
        if (tot_d == TOT_LAST) begin
          if (crc_rb_d == crc_tx_q) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      error_d = 1'b1;
    end

    scan_en_d = (state_d == S_SHIFT);
`ifdef SCAN_CFG_READBACK_EN
    scan_en_d = scan_en_d || (state_d == S_VERIFY);
`endif
    scan_data_d = (state_d == S_SHIFT) && sreg_d[0];
  end

  // Outputs are registered from the next state so the chain sees clean, edge-aligned levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      tot_q       <= '0;
      wcnt_q      <= '0;
      error_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_data_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      tot_q       <= tot_d;
      wcnt_q      <= wcnt_d;
      error_q     <= error_d;
      cfg_ready_q <= (state_d == S_LOAD);
      scan_en_q   <= scan_en_d;
      scan_data_q <= scan_data_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FINISH);
    end
  end

`ifdef SCAN_CFG_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_tx_q <= '0;
      crc_rb_q <= '0;
      verify_q <= 1'b0;
    end else begin
      crc_tx_q <= crc_tx_d;
      crc_rb_q <= crc_rb_d;
      verify_q <= (state_d == S_VERIFY);
    end
  end

  // Straight loopback so the chain rotates by exactly its own length and ends unchanged.
  assign scan_data = verify_q ? scan_ret : scan_data_q;
`else
  logic unused_scan_ret;
  assign unused_scan_ret = scan_ret;
  assign scan_data       = scan_data_q;
`endif

  assign cfg_ready = cfg_ready_q;
  assign scan_en   = scan_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// Bench for scan_cfg_ctrl: a per-load timeline model built from the word list, a cycle-by-cycle
// compare process, an external 29-bit chain model, and literal expectations for each scenario.
module tb_scan_cfg_ctrl;
  localparam int CHAIN_LEN = 29;
  localparam int WORD_W    = 8;
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int MAXC      = 128;
`ifdef SCAN_CFG_READBACK_EN
  localparam int VER_CYC = CHAIN_LEN;
`else
  localparam int VER_CYC = 0;
`endif

  logic              clk = 1'b0, rst_n = 1'b1;
  logic              start = 1'b0, abort = 1'b0, cfg_valid = 1'b0, flip = 1'b0;
  logic [WORD_W-1:0] cfg_data = '0;
  logic              cfg_ready, scan_en, scan_data, scan_ret, busy, done, error;
  logic [CHAIN_LEN-1:0] chain = '0;

  always #5 clk = ~clk;

  // Behavioural chain: scan_in enters at the top, bit 0 is the far (scan_out) end.
  always @(posedge clk) if (scan_en === 1'b1) chain <= {scan_data, chain[CHAIN_LEN-1:1]};
  assign scan_ret = chain[0] ^ flip;

  scan_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .scan_en(scan_en), .scan_data(scan_data), .scan_ret(scan_ret),
    .busy(busy), .done(done), .error(error)
  );

  // Per-cycle stimulus and expected outputs for one load, relative to its start cycle.
  logic        s_start[MAXC], s_abort[MAXC], s_valid[MAXC], s_flip[MAXC];
  logic [7:0]  s_data[MAXC];
  logic        e_ready[MAXC], e_en[MAXC], e_data[MAXC], e_busy[MAXC], e_done[MAXC], e_err[MAXC];
  int          plan_len = 0;
  logic        err_model = 1'b0;

  int   total = 0, bad = 0;
  int   pc = 0, en_cnt = 0, done_cnt = 0, done_cyc = -1;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (plan cycle %0d): got %0h, want %0h", name, pc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_ready", cfg_ready, e_ready[pc]);
      check("scan_en",   scan_en,   e_en[pc]);
      check("scan_data", scan_data, e_data[pc]);
      check("busy",      busy,      e_busy[pc]);
      check("done",      done,      e_done[pc]);
      check("error",     error,     e_err[pc]);
      if (scan_en === 1'b1) en_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = pc;
      end
    end
  end

  // Timeline from the rules: each word is a LOAD phase (gap stall cycles + handshake) followed by
  // min(WORD_W, bits left) shift cycles; the bit sent j-th overall is bit j of the packed words.
  task automatic build(input logic [31:0] words, input int gap, input int abort_at,
                       input int flip_at, input int busy_start_at);
    int   cur, h, k, rem, prev_h;
    logic fin_err;
    for (int c = 0; c < MAXC; c++) begin
      s_start[c] = 1'b0; s_abort[c] = 1'b0; s_valid[c] = 1'b0; s_flip[c] = 1'b0; s_data[c] = '0;
      e_ready[c] = 1'b0; e_en[c] = 1'b0; e_data[c] = 1'b0; e_busy[c] = 1'b0;
      e_done[c] = 1'b0; e_err[c] = 1'b0;
    end
    s_start[0] = 1'b1;
    if (busy_start_at > 0) s_start[busy_start_at] = 1'b1;
    cur = 1; rem = CHAIN_LEN; prev_h = 0;
    for (int w = 0; w < NWORDS; w++) begin
      h = cur + gap;
      for (int c = cur; c <= h; c++) begin e_ready[c] = 1'b1; e_busy[c] = 1'b1; end
      if (gap == 0) begin
        for (int c = prev_h + 1; c <= h; c++) begin s_valid[c] = 1'b1; s_data[c] = words[8*w +: 8]; end
      end else begin
        s_valid[h] = 1'b1; s_data[h] = words[8*w +: 8];
      end
      k = (rem < WORD_W) ? rem : WORD_W;
      for (int j = 0; j < k; j++) begin
        e_en[h+1+j] = 1'b1; e_busy[h+1+j] = 1'b1; e_data[h+1+j] = words[CHAIN_LEN-rem+j];
      end
      rem -= k; cur = h + k + 1; prev_h = h;
    end
    fin_err = 1'b0;
`ifdef SCAN_CFG_READBACK_EN
    for (int j = 0; j < CHAIN_LEN; j++) begin
      e_en[cur+j] = 1'b1; e_busy[cur+j] = 1'b1;
      s_flip[cur+j] = (j == flip_at);
      e_data[cur+j] = words[j] ^ (j == flip_at);
    end
    cur += CHAIN_LEN;
    if (flip_at >= 0) fin_err = 1'b1;
`endif
    if (!fin_err) begin e_busy[cur] = 1'b1; e_done[cur] = 1'b1; cur++; end
    plan_len = cur + 4;
    e_err[0] = err_model;
    for (int c = 1; c < MAXC; c++) e_err[c] = (c >= cur) ? fin_err : 1'b0;
    for (int c = cur; c < plan_len; c++) begin s_valid[c] = 1'b1; s_data[c] = 8'hFF; end
    if (abort_at > 0) begin
      s_abort[abort_at] = 1'b1;
      for (int c = abort_at + 1; c < MAXC; c++) begin
        e_ready[c] = 1'b0; e_en[c] = 1'b0; e_data[c] = 1'b0; e_busy[c] = 1'b0;
        e_done[c] = 1'b0; e_err[c] = 1'b1;
        s_valid[c] = 1'b0; s_flip[c] = 1'b0; s_start[c] = 1'b0;
      end
      plan_len = abort_at + 5;
    end
    err_model = e_err[plan_len-1];
  endtask

  task automatic run_plan(input int upto);
    en_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < upto; c++) begin
      @(posedge clk); #1;
      pc = c; chk_en = 1'b1;
      start = s_start[c]; abort = s_abort[c]; cfg_valid = s_valid[c];
      cfg_data = s_data[c]; flip = s_flip[c];
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; flip = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b0);
    check("rst_scan_en", scan_en, 1'b0);
    check("rst_scan_data", scan_data, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    rst_n = 1'b1;

    // Back-to-back source, with an extra start pulse while busy (cycle 5).
    build(32'h1B0F3CA5, 0, -1, -1, 5);
    run_plan(plan_len);
    check("a_en_cycles", en_cnt, 29);
    check("a_done_pulses", done_cnt, 1);
    check("a_done_cycle", done_cyc, 34 + VER_CYC);
    check("a_chain", chain, 29'h1B0F3CA5);
    $display("load back_to_back: scan_en_cycles=%0d done_pulses=%0d done_cycle=%0d", en_cnt, done_cnt, done_cyc);

    // Source stalls 3 cycles in front of every word.
    build(32'h1B0F3CA5, 3, -1, -1, 0);
    run_plan(plan_len);
    check("b_en_cycles", en_cnt, 29);
    check("b_done_pulses", done_cnt, 1);
    check("b_done_cycle", done_cyc, 46 + VER_CYC);
    check("b_chain", chain, 29'h1B0F3CA5);
    $display("load stalled: scan_en_cycles=%0d done_pulses=%0d done_cycle=%0d", en_cnt, done_cnt, done_cyc);

    // Abort during the 5th shift of the second word (shift cycles 11..18).
    build(32'hFFF0C35A, 0, 15, -1, 0);
    run_plan(plan_len);
    check("c_en_cycles", en_cnt, 13);
    check("c_done_pulses", done_cnt, 0);
    check("c_error_sticky", error, 1'b1);
    $display("load aborted: scan_en_cycles=%0d done_pulses=%0d error=%b", en_cnt, done_cnt, error);

    // Next load clears the sticky error, one-cycle stalls, different pattern.
    build(32'hE4007E81, 1, -1, -1, 0);
    run_plan(plan_len);
    check("d_en_cycles", en_cnt, 29);
    check("d_done_pulses", done_cnt, 1);
    check("d_chain", chain, 29'h04007E81);
    $display("load after_abort: scan_en_cycles=%0d done_pulses=%0d error=%b", en_cnt, done_cnt, error);

`ifdef SCAN_CFG_READBACK_EN
    // Corrupt one returned bit during readback.
    build(32'h1B0F3CA5, 0, -1, 7, 0);
    run_plan(plan_len);
    check("e_en_cycles", en_cnt, 58);
    check("e_done_pulses", done_cnt, 0);
    check("e_error", error, 1'b1);
    $display("load readback_fault: scan_en_cycles=%0d done_pulses=%0d error=%b", en_cnt, done_cnt, error);
`endif

    // Asynchronous reset in the middle of shifting the second word.
    build(32'h1B0F3CA5, 0, -1, -1, 0);
    run_plan(15);
    @(posedge clk); #2;
    check("pre_rst_scan_en", scan_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_scan_en", scan_en, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_cfg_ready", cfg_ready, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'h55;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_cfg_ready", cfg_ready, 1'b0);
      check("post_rst_scan_en", scan_en, 1'b0);
      check("post_rst_error", error, 1'b0);
    end
    cfg_valid = 1'b0;
    $display("reset mid_shift: busy=%b cfg_ready=%b scan_en=%b", busy, cfg_ready, scan_en);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
